// File: rtl/zl_uart_pkg.sv
// Shared constants and FSM encoding for the zl_uart transmitter and receiver.
package zl_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic START_BIT       = 1'b0;
    localparam logic STOP_BIT        = 1'b1;

endpackage

// File: rtl/zl_uart_baud.sv
// Bit-time generator: one-cycle bit_done strobe every CLKS_PER_BIT cycles while enabled;
// restart realigns the count to a new frame.
module zl_uart_baud #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic bit_done
);

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (restart) begin
            cnt <= RELOAD;
        end else if (!enable) begin
            cnt <= 16'd0;
        end else if (cnt == 16'd0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    assign bit_done = enable && (cnt == 16'd0);

endmodule

// File: rtl/zl_uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB first, STOP_BITS stop bits, with a
// one-byte holding buffer so consecutive frames run without an idle gap.
module zl_uart_tx
    import zl_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    tx_state_e  state;
    tx_state_e  next_state;
    logic [7:0] shift_q;
    logic [7:0] buf_q;
    logic       buf_full;
    logic [2:0] bit_cnt;
    logic       ready_en;
    logic       bit_done;
    logic       accept;
    logic       avail;
    logic       last_data;
    logic       last_stop;
    logic       start_frame;

    zl_uart_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state != IDLE),
        .restart (start_frame),
        .bit_done(bit_done)
    );

    assign last_data   = (state == DATA) && bit_done && (bit_cnt == 3'(FRAME_DATA_BITS - 1));
    assign last_stop   = (state == STOP) && bit_done && (bit_cnt == 3'(STOP_BITS - 1));
    // The buffer may be refilled on the same edge that hands its byte to the shifter.
    assign tx_ready    = ready_en && (!buf_full || last_stop);
    assign accept      = tx_valid && tx_ready;
    assign avail       = buf_full || accept;
    assign start_frame = ((state == IDLE) || last_stop) && avail;
    assign busy        = !((state == IDLE) && !buf_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no branch leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (avail)     next_state = START;
            START:   if (bit_done)  next_state = DATA;
            DATA:    if (last_data) next_state = STOP;
            STOP:    if (last_stop) next_state = avail ? START : IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: buffer contents are reset as well, so an aborted byte can never resurface.
            shift_q  <= 8'd0;
            buf_q    <= 8'd0;
            buf_full <= 1'b0;
            bit_cnt  <= 3'd0;
            ready_en <= 1'b0;
            tx       <= STOP_BIT;
        end else begin
            // NOTE: non-blocking throughout so every flop samples pre-edge values.
            ready_en <= 1'b1;

            case (state)
                START:   tx <= START_BIT;
                DATA:    tx <= shift_q[7];
                default: tx <= STOP_BIT;
            endcase

            if (start_frame || last_data || last_stop) begin
                bit_cnt <= 3'd0;
            end else if (bit_done && ((state == DATA) || (state == STOP))) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (start_frame) begin
                shift_q <= buf_full ? buf_q : tx_data;
            end else if ((state == DATA) && bit_done) begin
                shift_q <= {shift_q[6:0], 1'b0};
            end

            // An empty buffer with a frame starting means the byte went straight to the shifter.
            if (start_frame && buf_full) begin
                buf_full <= accept;
                if (accept) buf_q <= tx_data;
            end else if (accept && !start_frame) begin
                buf_q    <= tx_data;
                buf_full <= 1'b1;
            end
        end
    end

endmodule
